// File: rtl/cp0_pkg.sv
// Coprocessor-0 shared constants: register numbers, exception codes,
// Status/Cause field positions and reset values.
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  // Status bit positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;

  // Cause bit positions
  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IP_HI  = 15;
  localparam int CA_WP     = 22;
  localparam int CA_IV     = 23;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  // Software-writable Cause bits: IV, WP, IP[9:8]
  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

  // Reset values
  localparam logic [31:0] STATUS_RST = 32'h1000_0000;
  localparam logic [31:0] CONFIG_RST = 32'h0000_8000;

  // Registers that accept MTC0 (and so are candidates for read forwarding)
  function automatic logic is_writable(input logic [4:0] a);
    return (a == REG_COUNT) || (a == REG_COMPARE) || (a == REG_STATUS) ||
           (a == REG_CAUSE) || (a == REG_EPC);
  endfunction

endpackage

// File: rtl/cp0_if.sv
// Pipeline <-> CP0 bus: MTC0/MFC0 access, commit events, redirect and live regs.
interface cp0_if #(
  parameter int NUM_HW_INT = 6
);
  logic                  we_i;
  logic [4:0]            waddr_i;
  logic [31:0]           wdata_i;
  logic [4:0]            raddr_i;
  logic [31:0]           rdata_o;
  logic [NUM_HW_INT-1:0] int_i;
  logic                  exc_valid_i;
  logic [4:0]            exc_code_i;
  logic [31:0]           exc_pc_i;
  logic                  exc_bd_i;
  logic [31:0]           exc_badvaddr_i;
  logic                  eret_i;
  logic                  int_req_o;
  logic                  flush_o;
  logic [31:0]           new_pc_o;
  logic [31:0]           status_o;
  logic [31:0]           cause_o;
  logic [31:0]           epc_o;

  // Pipeline side
  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, int_i,
           exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
    input  rdata_o, int_req_o, flush_o, new_pc_o, status_o, cause_o, epc_o
  );

  // CP0 side
  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, int_i,
           exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
    output rdata_o, int_req_o, flush_o, new_pc_o, status_o, cause_o, epc_o
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: clock divider, free-running Count, Compare and sticky TI.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             div_wrap;

  assign div_wrap = (div == DIV_LAST);

  // Divider and Count; an MTC0 to Count reloads it and restarts the divider
  always_ff @(posedge clk) begin
    if (rst) begin
      div   <= '0;
      count <= '0;
    end else if (count_we) begin
      div   <= '0;
      count <= wdata;
    end else if (div_wrap) begin
      div   <= '0;
      count <= count + 32'd1;
    end else begin
      div   <= div + 1'b1;
    end
  end

  // Compare register
  always_ff @(posedge clk) begin
    if (rst)             compare <= '0;
    else if (compare_we) compare <= wdata;
  end

  // TI is sticky on a match and only an MTC0 to Compare clears it
  always_ff @(posedge clk) begin
    if (rst)                                        ti <= 1'b0;
    else if (compare_we)                            ti <= 1'b0;
    else if ((compare != '0) && (count == compare)) ti <= 1'b1;
  end

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 controller: Status/Cause/EPC/BadVAddr, exception & ERET commit,
// interrupt request, fetch redirect and MFC0 read path with forwarding.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] PRID       = 32'h004C_0102
) (
  input logic   clk,
  input logic   rst,
  cp0_if.slave  bus
);

  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic        cause_bd;
  logic        cause_iv;
  logic        cause_wp;
  logic [1:0]  sw_ip;
  logic [4:0]  exc_code;
  logic [5:0]  hw_ip;
  logic [5:0]  hw_ext;
  logic [7:0]  ip_live;
  logic [31:0] cause;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic        commit;
  logic        mtc0;
  logic [31:0] rdata;

  // A committing exception or ERET squashes any MTC0 in the same cycle
  assign commit = bus.exc_valid_i | bus.eret_i;
  assign mtc0   = bus.we_i & ~commit;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mtc0 && (bus.waddr_i == REG_COUNT)),
    .compare_we (mtc0 && (bus.waddr_i == REG_COMPARE)),
    .wdata      (bus.wdata_i),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // Zero-extend the hardware lines onto IP[7:2]; unused lines read 0
  always_comb begin
    hw_ext = '0;
    hw_ext[NUM_HW_INT-1:0] = bus.int_i;
  end

  // Hardware interrupt lines are sampled every cycle
  always_ff @(posedge clk) begin
    if (rst) hw_ip <= '0;
    else     hw_ip <= hw_ext;
  end

  // IP[7] shares the timer interrupt with the top hardware line
  assign ip_live = {hw_ip[5] | ti, hw_ip[4:0], sw_ip};
  assign cause   = {cause_bd, ti, 6'b0, cause_iv, cause_wp, 6'b0,
                    ip_live, 1'b0, exc_code, 2'b0};

  // Status: exception sets EXL, ERET clears it, otherwise MTC0 writes all bits
  always_ff @(posedge clk) begin
    if (rst)                                        status <= STATUS_RST;
    else if (bus.exc_valid_i)                       status[ST_EXL] <= 1'b1;
    else if (bus.eret_i)                            status[ST_EXL] <= 1'b0;
    else if (mtc0 && bus.waddr_i == REG_STATUS)     status <= bus.wdata_i;
  end

  // EPC and BD are captured only on the first exception (EXL clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      epc      <= '0;
      cause_bd <= 1'b0;
    end else if (bus.exc_valid_i) begin
      if (!status[ST_EXL]) begin
        epc      <= bus.exc_bd_i ? bus.exc_pc_i - 32'd4 : bus.exc_pc_i;
        cause_bd <= bus.exc_bd_i;
      end
    end else if (mtc0 && bus.waddr_i == REG_EPC) begin
      epc <= bus.wdata_i;
    end
  end

  // ExcCode on every exception; BadVAddr only for address errors
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_code <= '0;
      badvaddr <= '0;
    end else if (bus.exc_valid_i) begin
      exc_code <= bus.exc_code_i;
      if (bus.exc_code_i == EXC_ADEL || bus.exc_code_i == EXC_ADES)
        badvaddr <= bus.exc_badvaddr_i;
    end
  end

  // Software-writable Cause fields: IV, WP, IP[9:8]
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_iv <= 1'b0;
      cause_wp <= 1'b0;
      sw_ip    <= '0;
    end else if (mtc0 && bus.waddr_i == REG_CAUSE) begin
      cause_iv <= bus.wdata_i[CA_IV];
      cause_wp <= bus.wdata_i[CA_WP];
      sw_ip    <= bus.wdata_i[CA_IP_LO+1:CA_IP_LO];
    end
  end

  // One-cycle flush with redirect target; ERET uses the pre-update EPC
  always_ff @(posedge clk) begin
    if (rst) begin
      flush  <= 1'b0;
      new_pc <= '0;
    end else if (bus.exc_valid_i) begin
      flush  <= 1'b1;
      new_pc <= EXC_VECTOR;
    end else if (bus.eret_i) begin
      flush  <= 1'b1;
      new_pc <= epc;
    end else begin
      flush  <= 1'b0;
    end
  end

  // MFC0 read mux, forwarding a same-cycle MTC0 to the same register
  always_comb begin
    rdata = '0;
    case (bus.raddr_i)
      REG_BADVADDR: rdata = badvaddr;
      REG_COUNT:    rdata = count;
      REG_COMPARE:  rdata = compare;
      REG_STATUS:   rdata = status;
      REG_CAUSE:    rdata = cause;
      REG_EPC:      rdata = epc;
      REG_PRID:     rdata = PRID;
      REG_CONFIG:   rdata = CONFIG_RST;
      default:      rdata = '0;
    endcase
    if (bus.we_i && (bus.waddr_i == bus.raddr_i) && is_writable(bus.waddr_i)) begin
      if (bus.waddr_i == REG_CAUSE)
        rdata = (cause & ~CAUSE_WMASK) | (bus.wdata_i & CAUSE_WMASK);
      else
        rdata = bus.wdata_i;
    end
  end

  assign bus.rdata_o   = rdata;
  assign bus.int_req_o = status[ST_IE] & ~status[ST_EXL] &
                         (|(status[ST_IM_HI:ST_IM_LO] & cause[CA_IP_HI:CA_IP_LO]));
  assign bus.flush_o   = flush;
  assign bus.new_pc_o  = new_pc;
  assign bus.status_o  = status;
  assign bus.cause_o   = cause;
  assign bus.epc_o     = epc;

endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Parametrised coprocessor-0 controller for the MIPS32 core. It holds the Count, Compare, Status, Cause, EPC, BadVAddr, PrId and Config registers, and handles MTC0/MFC0 accesses. It also takes precise exceptions and ERET, computes the interrupt request, and redirects fetch. It sits beside the MEM/WB stage: MEM/WB supplies exception commits and MTC0 writes, and the decode path reads it for MFC0.

## Interface
Parameters:
- NUM_HW_INT, 6: hardware interrupt lines, 1..6, mapped to Cause.IP[2+NUM_HW_INT-1:2].
- COUNT_DIV, 2: core clocks per Count increment, >=1.
- EXC_VECTOR, 32'h0000_0020: fetch target on any exception.
- PRID, 32'h004C_0102: PrId value, read-only.

Ports:
- clk  in  1  clock clk.
- rst  in  1  reset rst, synchronous, active-high.
- we_i  in  1  MTC0 write enable.
- waddr_i  in  5  MTC0 register number.
- wdata_i  in  32  MTC0 data.
- raddr_i  in  5  MFC0 register number.
- rdata_o  out  32  MFC0 data, combinational.
- int_i  in  NUM_HW_INT  level hardware interrupts.
- exc_valid_i  in  1  exception commits this cycle.
- exc_code_i  in  5  ExcCode (0 Int, 4 AdEL, 5 AdES, 8 Sys, 10 RI, 12 Ov, 13 Tr).
- exc_pc_i  in  32  PC of the faulting instruction.
- exc_bd_i  in  1  faulting instruction is in a delay slot.
- exc_badvaddr_i  in  32  faulting address.
- eret_i  in  1  ERET commits this cycle.
- int_req_o  out  1  interrupt request to the pipeline.
- flush_o  out  1  pipeline flush pulse.
- new_pc_o  out  32  fetch redirect target, valid while flush_o is high.
- status_o, cause_o, epc_o  out  32 each  live register values.

## Operation
- Register numbers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, PrId 15, Config 16. Unmapped reads return 0.
- Reset values:
  - Status 32'h1000_0000.
  - Config 32'h0000_8000.
  - Count, Compare, Cause, EPC, BadVAddr: 0.
  - Count divider: 0.
  - flush_o: 0. new_pc_o: 0.
- Count: the divider counts 0..COUNT_DIV-1. Count increments (mod 2^32) when the divider wraps. An MTC0 to Count loads wdata and clears the divider.
- Timer: Cause.TI (bit 30) is set when Compare!=0 and Count==Compare. It is sticky and is cleared only by an MTC0 to Compare.
- Cause.IP[7] = int_i[5] OR TI when NUM_HW_INT=6; otherwise IP[7] = TI. The remaining IP bits are sampled from int_i every cycle, and unused IP bits read 0.
- Writable fields:
  - Status: all bits.
  - Cause: only IP[9:8], IV (23) and WP (22).
  - Count, Compare, EPC: all bits.
  - BadVAddr, PrId, Config: read-only; writes are ignored.
- int_req_o = Status.IE(0) & ~Status.EXL(1) & |(Status.IM[15:8] & Cause.IP[15:8]).
- Exception commit (exc_valid_i):
  - If EXL=0: EPC <= exc_bd_i ? exc_pc_i-4 : exc_pc_i, and Cause.BD(31) <= exc_bd_i. If EXL=1, EPC and BD are left unchanged.
  - EXL <= 1. Cause.ExcCode[6:2] <= exc_code_i.
  - For codes 4 and 5 only: BadVAddr <= exc_badvaddr_i.
- ERET commit: EXL <= 0.
- Priority within one cycle: exception > ERET > MTC0.
  - ERET is ignored when an exception also commits.
  - The MTC0 write is dropped entirely when an exception or ERET commits.
  - Count increment and IP sampling proceed regardless.
- Read forwarding: if we_i and waddr_i==raddr_i address a writable register, rdata_o returns the post-write masked value.

## Timing
- Register updates are visible the cycle after the clock edge.
- flush_o and new_pc_o are registered: high for exactly one cycle, the cycle after a commit. new_pc_o is EXC_VECTOR for an exception, or the pre-update EPC for ERET.
- Back-to-back commits produce back-to-back flush pulses.
- int_req_o falls in the cycle after an exception commit, because EXL rises.
- Reset mid-operation: all state returns to reset values at the next edge. A pending flush is dropped.

## Structure
- Package cp0_pkg holds:
  - register-number constants;
  - ExcCode constants;
  - Status/Cause bit-position constants (IE, EXL, IM, IP, TI, BD, ExcCode);
  - reset-value constants.
- One sub-module, cp0_timer: divider, Count, Compare and TI, with write ports for Count and Compare.

## Test plan
- Reset, then read all 8 registers -> Status 32'h1000_0000, Config 32'h0000_8000, PrId 32'h004C_0102, all others 0. flush_o=0.
- COUNT_DIV=2, Compare=10 -> Count reaches 10 after 20 cycles, TI=1, IP[7]=1. MTC0 Compare -> TI=0 on the next cycle.
- Status=32'h0000_8001, raise int_i[5] -> int_req_o=1. Commit exception code 0 at pc 32'h100 with bd=1 -> EPC=32'hFC, BD=1, EXL=1, flush_o pulse with new_pc_o=32'h20, int_req_o=0.
- Commit AdEL with badvaddr 32'hDEAD_BEE1 while EXL=1 -> EPC unchanged, ExcCode=4, BadVAddr updated.
- ERET with EPC=32'h200 -> EXL=0 and a one-cycle flush_o with new_pc_o=32'h200. An MTC0 issued in the same cycle is dropped.
- MTC0 Cause 32'hFFFF_FFFF with raddr=13 -> rdata_o shows only bits 23, 22, 9 and 8 set, plus the live IP bits.
